// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch queue unit: default widths, reset PC and queue entry layout.
package fetch_pkg;

    localparam int unsigned XLEN_DEF     = 64;
    localparam int unsigned ILEN_DEF     = 32;
    localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_0040_0000;

    // One queued instruction together with the byte address it was fetched from.
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN_DEF-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small flushable FIFO holding fetched instructions; flush empties it, reset also clears storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fq_entry_t
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  entry_t                 i_push_data,
    input  logic                   i_pop,
    output entry_t                 o_head_c,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    // Pointer and occupancy tracking; flush drops everything, including a same-cycle push.
    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Entry storage; cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head_c  = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_empty_c = (r_count == '0);

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: fetch PC, synchronous instruction memory and a decoupling queue.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN       = XLEN_DEF,
    parameter int unsigned      ILEN       = ILEN_DEF,
    parameter int unsigned      IMEM_DEPTH = 256,
    parameter int unsigned      FQ_DEPTH   = 4,
    parameter logic [XLEN-1:0]  RESET_PC   = XLEN'(RESET_PC_DEF)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [ILEN-1:0]               imem_wdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ILEN-1:0]               out_instr,
    output logic [XLEN-1:0]               out_pc,
    output logic                          misalign_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                   fetch_count,
    output logic [31:0]                   stall_count
`endif
);

    localparam int unsigned AW    = $clog2(IMEM_DEPTH);
    localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    logic [ILEN-1:0]  r_imem [IMEM_DEPTH];
    logic [XLEN-1:0]  r_fetch_pc;
    logic [XLEN-1:0]  r_rd_pc;
    logic [ILEN-1:0]  r_rd_data;
    logic             r_inflight;
    logic             r_misalign;

    logic             w_issue;
    logic             w_xfer;
    logic [AW-1:0]    w_raddr;
    logic [CNT_W-1:0] w_count;
    logic             w_empty;
    entry_t           w_push_entry;
    entry_t           w_head;

    assign w_raddr = r_fetch_pc[AW+1:2];
    assign w_xfer  = out_valid && out_ready;
    // Queued plus in-flight entries must never exceed the queue depth.
    assign w_issue = !redirect_valid && ((w_count + CNT_W'(r_inflight)) < CNT_W'(FQ_DEPTH));

    // Fetch PC, in-flight tracking and sticky misalignment flag; redirect cancels the in-flight read.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_rd_pc    <= '0;
            r_inflight <= 1'b0;
            r_misalign <= 1'b0;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            r_inflight <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) r_misalign <= 1'b1;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
                r_rd_pc    <= r_fetch_pc;
            end
        end
    end

    // Instruction memory: not reset, read-before-write on a same-word collision.
    always_ff @(posedge clock) begin
        if (imem_we) r_imem[imem_waddr] <= imem_wdata;
        if (w_issue) r_rd_data <= r_imem[w_raddr];
    end

    assign w_push_entry = '{pc: r_rd_pc, instr: r_rd_data};

    fetch_fifo #(
        .DEPTH   (FQ_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_flush     (redirect_valid),
        .i_push      (r_inflight),
        .i_push_data (w_push_entry),
        .i_pop       (w_xfer),
        .o_head_c    (w_head),
        .o_count     (w_count),
        .o_empty_c   (w_empty)
    );

    assign out_valid    = !w_empty;
    assign out_instr    = w_head.instr;
    assign out_pc       = w_head.pc;
    assign misalign_err = r_misalign;

`ifdef FETCH_PERF_CNT_EN
    // Delivered-instruction and consumer-stall counters, free-running with natural wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (w_xfer)                   fetch_count <= fetch_count + 32'd1;
            if (out_valid && !out_ready)  stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit using an expected-entry scoreboard.
module tb_fetch_queue_unit;
    import fetch_pkg::*;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned ILEN       = 32;
    localparam int unsigned IMEM_DEPTH = 256;
    localparam int unsigned FQ_DEPTH   = 4;
    localparam logic [63:0] BASE_PC    = 64'h0000_0000_0040_0000;

    logic            clock;
    logic            reset;
    logic            redirect_valid;
    logic [63:0]     redirect_pc;
    logic            imem_we;
    logic [7:0]      imem_waddr;
    logic [31:0]     imem_wdata;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [63:0]     out_pc;
    logic            misalign_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]     fetch_count;
    logic [31:0]     stall_count;
`endif

    int checks = 0;
    int errors = 0;
    fq_entry_t exp_q[$];

    fetch_queue_unit #(
        .XLEN(XLEN), .ILEN(ILEN), .IMEM_DEPTH(IMEM_DEPTH), .FQ_DEPTH(FQ_DEPTH), .RESET_PC(BASE_PC)
    ) dut (
        .clock(clock), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .misalign_err(misalign_err)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] instr_at(input logic [63:0] pc);
        logic [7:0] w;
        w = pc[9:2];
        return 32'h0042_8233 + 32'(w);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        reset = 1'b1; redirect_valid = 1'b0; out_ready = rdy;
        step(); step();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic push_exp(input logic [63:0] start, input int n);
        fq_entry_t e;
        for (int i = 0; i < n; i++) begin
            e.pc    = start + 64'(4 * i);
            e.instr = instr_at(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h0040_0006;
        for (int i = 0; i < int'(IMEM_DEPTH); i++) begin
            imem_we = 1'b1; imem_waddr = 8'(i); imem_wdata = 32'h0042_8233 + 32'(i);
            step();
        end
        imem_we = 1'b0; redirect_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        checks++; if (out_pc !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", out_pc); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", out_instr); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %0b want 0", misalign_err); end
    endtask

    task automatic test_stream();
        int lat;
        fq_entry_t e;
        do_reset(1'b1);
        push_exp(BASE_PC, 8);
        wait_valid(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL stream_latency: got %0d want 2", lat); end
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %0b want 1", i, out_valid); end
            checks++; if (out_pc !== e.pc) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", i, out_pc, e.pc); end
            checks++; if (out_instr !== e.instr) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", i, out_instr, e.instr); end
            step();
        end
    endtask

    task automatic test_backpressure();
        fq_entry_t e;
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            if (i >= 1) begin
                checks++; if (out_valid !== 1'b1 || out_pc !== BASE_PC) begin
                    errors++; $display("FAIL hold_head[%0d]: got valid %0b pc %h want 1 %h", i, out_valid, out_pc, BASE_PC);
                end
            end
        end
        push_exp(BASE_PC, 10);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            e = exp_q.pop_front();
            checks++; if (out_valid !== 1'b1 || out_pc !== e.pc) begin
                errors++; $display("FAIL drain_pc[%0d]: got valid %0b pc %h want 1 %h", i, out_valid, out_pc, e.pc);
            end
            checks++; if (out_instr !== e.instr) begin errors++; $display("FAIL drain_instr[%0d]: got %h want %h", i, out_instr, e.instr); end
            step();
        end
    endtask

    task automatic test_redirect_full();
        int lat;
        fq_entry_t e;
        do_reset(1'b0);
        repeat (10) step();
        redirect_valid = 1'b1; redirect_pc = 64'h0040_0010;
        step();
        redirect_valid = 1'b0; out_ready = 1'b1;
        wait_valid(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL redir_latency: got %0d want 2", lat); end
        push_exp(64'h0040_0010, 4);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            checks++; if (out_valid !== 1'b1 || out_pc !== e.pc) begin
                errors++; $display("FAIL redir_pc[%0d]: got valid %0b pc %h want 1 %h", i, out_valid, out_pc, e.pc);
            end
            checks++; if (out_instr !== e.instr) begin errors++; $display("FAIL redir_instr[%0d]: got %h want %h", i, out_instr, e.instr); end
            step();
        end
    endtask

    task automatic test_misalign();
        int lat;
        fq_entry_t e;
        do_reset(1'b1);
        repeat (4) step();
        redirect_valid = 1'b1; redirect_pc = 64'h0040_0006;
        step();
        redirect_valid = 1'b0;
        checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL misalign_set: got %0b want 1", misalign_err); end
        wait_valid(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL misalign_latency: got %0d want 2", lat); end
        push_exp(64'h0040_0004, 2);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            checks++; if (out_pc !== e.pc || out_instr !== e.instr) begin
                errors++; $display("FAIL misalign_fetch[%0d]: got %h/%h want %h/%h", i, out_pc, out_instr, e.pc, e.instr);
            end
            step();
        end
        step(); step();
        checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL misalign_sticky: got %0b want 1", misalign_err); end
        reset = 1'b1;
        step();
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL misalign_clear: got %0b want 0", misalign_err); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %0b want 0", out_valid); end
        reset = 1'b0;
    endtask

    task automatic test_redirect_transfer();
        int lat;
        int seen_old;
        fq_entry_t e;
        do_reset(1'b1);
        wait_valid(lat);
        step(); step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h0040_0008) begin
            errors++; $display("FAIL rt_head: got valid %0b pc %h want 1 0000000000400008", out_valid, out_pc);
        end
        redirect_valid = 1'b1; redirect_pc = 64'h0040_0100;
        step();
        redirect_valid = 1'b0;
        wait_valid(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL rt_latency: got %0d want 2", lat); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL rt_fetch_count: got %0d want 3", fetch_count); end
`endif
        push_exp(64'h0040_0100, 4);
        seen_old = 0;
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            if (out_pc == 64'h0040_0008) seen_old++;
            checks++; if (out_valid !== 1'b1 || out_pc !== e.pc || out_instr !== e.instr) begin
                errors++; $display("FAIL rt_stream[%0d]: got %0b %h/%h want 1 %h/%h", i, out_valid, out_pc, out_instr, e.pc, e.instr);
            end
            step();
        end
        checks++; if (seen_old != 0) begin errors++; $display("FAIL rt_repeat: got %0d repeats want 0", seen_old); end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        int lat;
        do_reset(1'b1);
        checks++; if (fetch_count !== 32'd0 || stall_count !== 32'd0) begin
            errors++; $display("FAIL perf_reset: got %0d/%0d want 0/0", fetch_count, stall_count);
        end
        wait_valid(lat);
        repeat (3) step();
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        repeat (2) step();
        out_ready = 1'b0;
        checks++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL perf_fetch: got %0d want 5", fetch_count); end
        checks++; if (stall_count !== 32'd3) begin errors++; $display("FAIL perf_stall: got %0d want 3", stall_count); end
    endtask
`endif

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0; out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_misalign();
        test_redirect_transfer();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
